coarse_seq: RTL and testbench

- Sequencer for the coarse resolver comparator.
- Owns the 15-bit CDU read counter.
- Decodes the counter's top bits into the twelve switch drives `_DC1`..`_DC12` that feed the summing amplifier.
- Samples the Schmitt error `_TLC1H`, its sign and the ambiguity detect `_ADHI` once per reference cycle, and steps the counter until the coarse error nulls. It then tracks, and applies fine-system count pulses.

---
 rtl/coarse_pkg.sv | 26 ++
 rtl/coarse_seq_if.sv | 30 +++
 rtl/coarse_dc_decode.sv | 37 +++
 rtl/coarse_seq.sv | 177 +++++++++++++++++
 tb/tb_coarse_seq.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/coarse_pkg.sv
// Shared types and constants for the coarse resolver sequencer: state encoding,
// fault codes, counter width and the octant-to-switch-drive table.
package coarse_pkg;

  localparam int CNT_W = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_STEP,
    ST_FLIP,
    ST_NULL,
    ST_HALT
  } state_e;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b01;
  localparam logic [1:0] FAULT_AMBIG   = 2'b10;

  // Sine + cosine drive pair per octant; bit 0 = DC1 ... bit 7 = DC8.
  localparam logic [7:0] OCT_DC [8] = '{
    8'h14, 8'h28, 8'h22, 8'h11, 8'h41, 8'h82, 8'h88, 8'h44
  };

endpackage

// File: rtl/coarse_seq_if.sv
// Control/status bundle between the coarse sequencer (slave) and its driver (master).
interface coarse_seq_if;
  import coarse_pkg::*;

  logic             enable;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             ref_zc;
  logic             _TLC1H;
  logic             err_pos;
  logic             _ADHI;
  logic             fine_up;
  logic             fine_dn;
  logic [11:0]      dc;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             coarse_ok;
  logic [1:0]       fault;

  modport master (
    output enable, load, load_val, ref_zc, _TLC1H, err_pos, _ADHI, fine_up, fine_dn,
    input  dc, cnt, busy, coarse_ok, fault
  );

  modport slave (
    input  enable, load, load_val, ref_zc, _TLC1H, err_pos, _ADHI, fine_up, fine_dn,
    output dc, cnt, busy, coarse_ok, fault
  );

endinterface

// File: rtl/coarse_dc_decode.sv
// Registered decode of the counter's top seven bits into the twelve switch drives,
// plus a one-cycle flag whenever the registered drive pattern changes.
module coarse_dc_decode
  import coarse_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  cnt_hi_i,
  output logic [11:0] dc_o,
  output logic        chg_o
);

  logic [11:0] dc_d, dc_q;
  logic        chg_q;
  logic [3:0]  fine_bits;

  // cnt[11] lands on DC9 (bit 8), cnt[8] on DC12 (bit 11).
  for (genvar gi = 0; gi < 4; gi++) begin : g_fine
    assign fine_bits[gi] = cnt_hi_i[3 - gi];
  end

  assign dc_d = {fine_bits, OCT_DC[cnt_hi_i[6:4]]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dc_q  <= {4'b0000, OCT_DC[0]};
      chg_q <= 1'b0;
    end else begin
      dc_q  <= dc_d;
      chg_q <= (dc_d != dc_q);
    end
  end

  assign dc_o  = dc_q;
  assign chg_o = chg_q;

endmodule

// File: rtl/coarse_seq.sv
// Coarse resolver sequencer: steps the CDU read counter until the coarse error nulls.
// Define COARSE_BINARY_SEARCH_EN to halve the step size on each error-sign reversal.
module coarse_seq
  import coarse_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int STEP_LOG2     = 6,
  parameter int MAX_STEPS     = 512,
  parameter int MAX_FLIPS     = 2
) (
  input logic         clk,
  input logic         rst,
  coarse_seq_if.slave bus
);

  localparam int TW = $clog2(SETTLE_CYCLES + 1);
  localparam int SW = $clog2(MAX_STEPS + 1);
  localparam int FW = $clog2(MAX_FLIPS + 2);
  localparam logic [CNT_W-1:0] HALF_TURN = CNT_W'(1) << (CNT_W - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, coarse_delta, step_mag;
  logic [TW-1:0]    timer_q, timer_d;
  logic [SW-1:0]    step_cnt_q, step_cnt_d;
  logic [FW-1:0]    flip_cnt_q, flip_cnt_d;
  logic [1:0]       fault_q, fault_d;
  logic             enable_q;
  logic [11:0]      dc;
  logic             dc_chg, en_rise, sampling, step_last, flip_over;
  logic             busy, coarse_ok;

  assign en_rise   = bus.enable && !enable_q;
  assign sampling  = bus.ref_zc && (timer_q == '0);
  assign step_last = (step_cnt_q == SW'(MAX_STEPS - 1));
  assign flip_over = (flip_cnt_q == FW'(MAX_FLIPS));

  coarse_dc_decode u_dec (
    .clk      (clk),
    .rst      (rst),
    .cnt_hi_i (cnt_q[CNT_W-1:8]),
    .dc_o     (dc),
    .chg_o    (dc_chg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (en_rise) state_d = ST_SETTLE;
      ST_SETTLE: if (timer_q == '0) state_d = ST_SAMPLE;
      ST_SAMPLE: if (sampling) begin
        if (bus._TLC1H)    state_d = ST_STEP;
        else if (bus._ADHI) state_d = ST_FLIP;
        else                state_d = ST_NULL;
      end
      ST_STEP:   state_d = step_last ? ST_HALT : ST_SETTLE;
      ST_FLIP:   state_d = flip_over ? ST_HALT : ST_SETTLE;
      ST_NULL:   if (bus.ref_zc && bus._TLC1H) state_d = ST_STEP;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
    // HALT is left only through enable low, so a load does not restart it.
    if (bus.load && state_q != ST_IDLE && state_q != ST_HALT) state_d = ST_SETTLE;
    if (!bus.enable) state_d = ST_IDLE;
  end

  always_comb begin
    busy      = !(state_q == ST_IDLE || state_q == ST_NULL);
    coarse_ok = (state_q == ST_NULL);
  end

`ifdef COARSE_BINARY_SEARCH_EN
  localparam int HW = $clog2(STEP_LOG2 + 2);
  logic [HW-1:0] shift_q, shift_d;
  logic          last_pos_q, have_last_q;

  // shift_d is the exponent used by the step in flight.
  always_comb begin
    shift_d = shift_q;
    if (have_last_q && (bus.err_pos != last_pos_q) && (shift_q != '0))
      shift_d = shift_q - HW'(1);
    step_mag = CNT_W'(1) << shift_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= HW'(STEP_LOG2);
      last_pos_q  <= 1'b0;
      have_last_q <= 1'b0;
    end else if (state_q == ST_IDLE || state_q == ST_FLIP || bus.load) begin
      shift_q     <= HW'(STEP_LOG2);
      have_last_q <= 1'b0;
    end else if (state_q == ST_STEP) begin
      shift_q     <= shift_d;
      last_pos_q  <= bus.err_pos;
      have_last_q <= 1'b1;
    end
  end
`else
  assign step_mag = CNT_W'(1) << STEP_LOG2;
`endif

  always_comb begin
    coarse_delta = '0;
    if (state_q == ST_STEP)
      coarse_delta = bus.err_pos ? step_mag : (CNT_W'(0) - step_mag);
    else if (state_q == ST_FLIP && !flip_over)
      coarse_delta = HALF_TURN;
    cnt_d = bus.load ? bus.load_val
                     : cnt_q + coarse_delta + CNT_W'(bus.fine_up) - CNT_W'(bus.fine_dn);
  end

  always_comb begin
    step_cnt_d = step_cnt_q;
    flip_cnt_d = flip_cnt_q;
    fault_d    = fault_q;
    case (state_q)
      ST_IDLE: begin
        step_cnt_d = '0;
        flip_cnt_d = '0;
      end
      ST_NULL: step_cnt_d = '0;
      ST_STEP: begin
        step_cnt_d = step_cnt_q + SW'(1);
        if (step_last) fault_d = FAULT_TIMEOUT;
      end
      ST_FLIP: begin
        if (flip_over) fault_d = FAULT_AMBIG;
        else           flip_cnt_d = flip_cnt_q + FW'(1);
      end
      default: ;
    endcase
    if (bus.load) begin
      step_cnt_d = '0;
      flip_cnt_d = '0;
    end
    if (!bus.enable) fault_d = FAULT_NONE;
  end

  // Settling restarts on any drive change and on every entry into SETTLE.
  always_comb begin
    timer_d = timer_q;
    if (dc_chg || (state_d == ST_SETTLE && state_q != ST_SETTLE))
      timer_d = TW'(SETTLE_CYCLES);
    else if (timer_q != '0)
      timer_d = timer_q - TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      timer_q    <= '0;
      step_cnt_q <= '0;
      flip_cnt_q <= '0;
      fault_q    <= FAULT_NONE;
      enable_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      step_cnt_q <= step_cnt_d;
      flip_cnt_q <= flip_cnt_d;
      fault_q    <= fault_d;
      enable_q   <= bus.enable;
    end
  end

  assign bus.cnt       = cnt_q;
  assign bus.dc        = dc;
  assign bus.busy      = busy;
  assign bus.coarse_ok = coarse_ok;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_coarse_seq.sv
// Scoreboard bench for coarse_seq: expected counter values are queued as stimulus is
// driven and popped when the counter moves; status outputs are checked inline.
module tb_coarse_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [14:0] exp_q[$];

  always #5 clk = ~clk;

  coarse_seq_if bus();

  coarse_seq #(
    .SETTLE_CYCLES (16),
    .STEP_LOG2     (6),
    .MAX_STEPS     (8),
    .MAX_FLIPS     (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic zc(input logic tlc, input logic pos, input logic adhi);
    repeat (31) @(negedge clk);
    bus._TLC1H  = tlc;
    bus.err_pos = pos;
    bus._ADHI   = adhi;
    bus.ref_zc  = 1'b1;
    @(negedge clk);
    bus.ref_zc  = 1'b0;
  endtask

  task automatic do_load(input logic [14:0] v);
    bus.load_val = v;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic wait_cnt_change(output bit got);
    logic [14:0] prev;
    prev = bus.cnt;
    got  = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (bus.cnt !== prev) got = 1'b1;
    end
  endtask

  task automatic disable_seq();
    bus.enable = 1'b0;
    bus._TLC1H = 1'b0;
    bus._ADHI  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [14:0] e;
    bit got;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.cnt !== 15'h0000) begin failures++; $display("FAIL reset_cnt got=%h want=0000", bus.cnt); end
    checks++; if (bus.dc !== 12'h014) begin failures++; $display("FAIL reset_dc got=%h want=014", bus.dc); end
    checks++; if (bus.busy !== 1'b0 || bus.coarse_ok !== 1'b0) begin failures++; $display("FAIL reset_status busy=%b ok=%b want 0 0", bus.busy, bus.coarse_ok); end
    checks++; if (bus.fault !== 2'b00) begin failures++; $display("FAIL reset_fault got=%b want=00", bus.fault); end
    exp_q.push_back(15'h2A00);
    do_load(15'h2A00);
    e = exp_q.pop_front();
    checks++; if (bus.cnt !== e) begin failures++; $display("FAIL load_cnt got=%h want=%h", bus.cnt, e); end
    bus.enable = 1'b1;
    zc(1'b1, 1'b1, 1'b0);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL midstep_busy got=%b want=1", bus.busy); end
    checks++; if (bus.dc !== 12'h522) begin failures++; $display("FAIL pre_reset_dc got=%h want=522", bus.dc); end
    rst = 1'b1;
    #1;
    checks++; if (bus.cnt !== 15'h0000) begin failures++; $display("FAIL async_reset_cnt got=%h want=0000", bus.cnt); end
    checks++; if (bus.dc !== 12'h014) begin failures++; $display("FAIL async_reset_dc got=%h want=014", bus.dc); end
    checks++; if (bus.busy !== 1'b0 || bus.fault !== 2'b00 || bus.coarse_ok !== 1'b0) begin
      failures++; $display("FAIL async_reset_status busy=%b fault=%b ok=%b want 0 00 0", bus.busy, bus.fault, bus.coarse_ok);
    end
    disable_seq();
    rst = 1'b0;
    wait_cnt_change(got);
    checks++; if (got || bus.cnt !== 15'h0000) begin failures++; $display("FAIL post_reset_hold cnt=%h want=0000", bus.cnt); end
    $display("test_reset done cnt=%h", bus.cnt);
  endtask

  task automatic test_align();
    logic [14:0] e;
    bit got;
    do_load(15'h2A00);
    bus.enable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(15'h2A00 + 15'(64 * k));
      zc(1'b1, 1'b1, 1'b0);
      wait_cnt_change(got);
      e = exp_q.pop_front();
      checks++; if (!got || bus.cnt !== e) begin failures++; $display("FAIL align_step%0d got=%h want=%h", k, bus.cnt, e); end
      $display("align step %0d cnt=%h", k, bus.cnt);
    end
    zc(1'b0, 1'b0, 1'b0);
    checks++; if (bus.coarse_ok !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL align_null ok=%b busy=%b want 1 0", bus.coarse_ok, bus.busy); end
    checks++; if (bus.dc !== 12'h522) begin failures++; $display("FAIL align_dc got=%h want=522", bus.dc); end
    // a new error in NULL steps again and drops coarse_ok
    exp_q.push_back(15'h2B00);
    zc(1'b1, 1'b1, 1'b0);
    checks++; if (bus.coarse_ok !== 1'b0) begin failures++; $display("FAIL null_restep_ok got=%b want=0", bus.coarse_ok); end
    wait_cnt_change(got);
    e = exp_q.pop_front();
    checks++; if (!got || bus.cnt !== e) begin failures++; $display("FAIL null_restep_cnt got=%h want=%h", bus.cnt, e); end
    disable_seq();
  endtask

  task automatic test_ambiguity();
    logic [14:0] e;
    do_load(15'h0100);
    bus.enable = 1'b1;
    exp_q.push_back(15'h4100);
    exp_q.push_back(15'h0100);
    for (int k = 1; k <= 2; k++) begin
      bit got;
      zc(1'b0, 1'b0, 1'b1);
      wait_cnt_change(got);
      e = exp_q.pop_front();
      checks++; if (!got || bus.cnt !== e) begin failures++; $display("FAIL flip%0d_cnt got=%h want=%h", k, bus.cnt, e); end
      if (k == 1) begin
        @(negedge clk);
        checks++; if (bus.dc !== 12'h841) begin failures++; $display("FAIL flip_dc got=%h want=841", bus.dc); end
      end
      $display("flip %0d cnt=%h", k, bus.cnt);
    end
    zc(1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checks++; if (bus.fault !== 2'b10) begin failures++; $display("FAIL ambig_fault got=%b want=10", bus.fault); end
    checks++; if (bus.busy !== 1'b1 || bus.coarse_ok !== 1'b0) begin failures++; $display("FAIL ambig_halt busy=%b ok=%b want 1 0", bus.busy, bus.coarse_ok); end
    checks++; if (bus.cnt !== 15'h0100) begin failures++; $display("FAIL ambig_cnt got=%h want=0100", bus.cnt); end
    bus.enable = 1'b0;
    @(negedge clk);
    checks++; if (bus.fault !== 2'b00 || bus.busy !== 1'b0) begin failures++; $display("FAIL ambig_clear fault=%b busy=%b want 00 0", bus.fault, bus.busy); end
    disable_seq();
  endtask

  task automatic test_timeout();
    logic [14:0] e;
    bit got;
    do_load(15'h1000);
    bus.enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back(15'h1000 + 15'(64 * k));
      zc(1'b1, 1'b1, 1'b0);
      wait_cnt_change(got);
      e = exp_q.pop_front();
      checks++; if (!got || bus.cnt !== e) begin failures++; $display("FAIL timeout_step%0d got=%h want=%h", k, bus.cnt, e); end
      if (k == 7) begin
        checks++; if (bus.fault !== 2'b00) begin failures++; $display("FAIL early_fault got=%b want=00", bus.fault); end
      end
    end
    checks++; if (bus.fault !== 2'b01 || bus.busy !== 1'b1) begin failures++; $display("FAIL timeout_fault fault=%b busy=%b want 01 1", bus.fault, bus.busy); end
    zc(1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (bus.cnt !== 15'h1200) begin failures++; $display("FAIL halt_no_step got=%h want=1200", bus.cnt); end
    $display("timeout fault=%b cnt=%h", bus.fault, bus.cnt);
    bus.enable = 1'b0;
    @(negedge clk);
    checks++; if (bus.fault !== 2'b00 || bus.busy !== 1'b0) begin failures++; $display("FAIL timeout_clear fault=%b busy=%b want 00 0", bus.fault, bus.busy); end
    disable_seq();
  endtask

  task automatic test_wrap();
    logic [14:0] e;
    bit got;
    do_load(15'h7FFF);
    exp_q.push_back(15'h0000);
    exp_q.push_back(15'h0000);
    exp_q.push_back(15'h7FFF);
    bus.fine_up = 1'b1; @(negedge clk); bus.fine_up = 1'b0;
    e = exp_q.pop_front();
    checks++; if (bus.cnt !== e) begin failures++; $display("FAIL wrap_up got=%h want=%h", bus.cnt, e); end
    bus.fine_up = 1'b1; bus.fine_dn = 1'b1; @(negedge clk); bus.fine_up = 1'b0; bus.fine_dn = 1'b0;
    e = exp_q.pop_front();
    checks++; if (bus.cnt !== e) begin failures++; $display("FAIL fine_cancel got=%h want=%h", bus.cnt, e); end
    bus.fine_dn = 1'b1; @(negedge clk); bus.fine_dn = 1'b0;
    e = exp_q.pop_front();
    checks++; if (bus.cnt !== e) begin failures++; $display("FAIL wrap_dn got=%h want=%h", bus.cnt, e); end
    do_load(15'h0000);
    bus.enable = 1'b1;
    exp_q.push_back(15'h7FC0);
    zc(1'b1, 1'b0, 1'b0);
    wait_cnt_change(got);
    e = exp_q.pop_front();
    checks++; if (!got || bus.cnt !== e) begin failures++; $display("FAIL wrap_step_dn got=%h want=%h", bus.cnt, e); end
    $display("wrap cnt=%h", bus.cnt);
    disable_seq();
  endtask

  task automatic test_search();
    logic [14:0] c, e;
    int sz;
    bit got;
    c  = 15'h2000;
    sz = 64;
    do_load(c);
    bus.enable = 1'b1;
    for (int k = 0; k < 7; k++) begin
      logic pos;
      pos = (k % 2 == 0);
`ifdef COARSE_BINARY_SEARCH_EN
      if (k > 0) sz = (sz > 1) ? sz / 2 : 1;
`endif
      c = pos ? c + 15'(sz) : c - 15'(sz);
      exp_q.push_back(c);
      zc(1'b1, pos, 1'b0);
      wait_cnt_change(got);
      e = exp_q.pop_front();
      checks++; if (!got || bus.cnt !== e) begin failures++; $display("FAIL search_step%0d got=%h want=%h", k, bus.cnt, e); end
      $display("search step %0d delta=%0d cnt=%h", k, pos ? sz : -sz, bus.cnt);
    end
    zc(1'b0, 1'b0, 1'b0);
    checks++; if (bus.coarse_ok !== 1'b1) begin failures++; $display("FAIL search_null got=%b want=1", bus.coarse_ok); end
    disable_seq();
  endtask

  initial begin
    bus.enable = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.ref_zc = 1'b0;
    bus._TLC1H = 1'b0; bus.err_pos = 1'b0; bus._ADHI = 1'b0;
    bus.fine_up = 1'b0; bus.fine_dn = 1'b0;
    test_reset();
    test_align();
    test_ambiguity();
    test_timeout();
    test_wrap();
    test_search();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
